// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: synchronise + debounce active-low buttons, filter reversals, commit on move_tick.
// Latency: raw button change -> pending_valid after DEBOUNCE_CYCLES+3 edges; pending -> move_direction on the move_tick edge.
// Backpressure: none; one pending slot, a newer accepted request overwrites it, uncommitted requests wait for move_tick.
//
// Ports:
//   clk            system clock, all state on rising edge
//   reset          asynchronous active-low reset
//   btn_n[3:0]     raw active-low buttons (bit0 left, bit1 up, bit2 right, bit3 down)
//   move_tick      one-cycle game-step strobe
//   move_direction committed direction (0 left, 1 up, 2 right, 3 down)
//   pending_dir    direction waiting for the next move_tick
//   pending_valid  pending_dir holds an accepted, uncommitted request
//   dir_changed    one-cycle pulse, move_direction updated on this edge
module snake_dir_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [1:0] RESET_DIR       = 2'd2,
    parameter bit         ALLOW_REVERSE   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_n,
    input  logic       move_tick,
    output logic [1:0] move_direction,
    output logic [1:0] pending_dir,
    output logic       pending_valid,
    output logic       dir_changed
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Synchroniser and debounce state (1 = released)
    logic [3:0]          sync1_q;
    logic [3:0]          sync2_q;
    logic [3:0]          stable_q;
    logic [3:0]          stable_d;
    logic [3:0]          stable_prev_q;
    logic [3:0][CW-1:0]  cnt_q;
    logic [3:0][CW-1:0]  cnt_d;

    // Direction state
    logic [1:0] move_dir_q;
    logic [1:0] move_dir_d;
    logic [1:0] pend_dir_q;
    logic [1:0] pend_dir_d;
    logic       pend_vld_q;
    logic       pend_vld_d;
    logic       dir_chg_q;
    logic       dir_chg_d;

    // Request decode
    logic [3:0] press;
    logic       req_vld;
    logic [1:0] req_dir;
    logic [1:0] ref_dir;
    logic       req_is_rev;
    logic       req_accept;

    // Debounce: the stable level flips only after DEBOUNCE_CYCLES consecutive
    // synchronised samples that disagree with it; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press event = debounced level went released -> pressed on the previous edge.
    // Releases and long holds generate nothing.
    assign press = stable_prev_q & ~stable_q;

    // Lowest bit index wins; scanning downward lets the lowest set bit write last.
    always_comb begin
        req_vld = 1'b0;
        req_dir = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) begin
                req_vld = 1'b1;
                req_dir = 2'(i);
            end
        end
    end

    // Requests are judged against the direction the snake will be heading next:
    // the pending one if present, otherwise the committed one. Directions are
    // encoded so the opposite is the value with bit 1 flipped.
    assign ref_dir    = pend_vld_q ? pend_dir_q : move_dir_q;
    assign req_is_rev = (req_dir == (ref_dir ^ 2'd2));
    assign req_accept = req_vld && (req_dir != ref_dir) && (ALLOW_REVERSE || !req_is_rev);

    // Commit happens first, then an accepted request refills the pending slot,
    // so a press coinciding with move_tick survives as the new pending request.
    always_comb begin
        move_dir_d = move_dir_q;
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        dir_chg_d  = 1'b0;
        if (move_tick && pend_vld_q) begin
            move_dir_d = pend_dir_q;
            pend_vld_d = 1'b0;
            dir_chg_d  = 1'b1;
        end
        if (req_accept) begin
            pend_dir_d = req_dir;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= 4'hF;
            sync2_q       <= 4'hF;
            stable_q      <= 4'hF;
            stable_prev_q <= 4'hF;
            cnt_q         <= '0;
            move_dir_q    <= RESET_DIR;
            pend_dir_q    <= RESET_DIR;
            pend_vld_q    <= 1'b0;
            dir_chg_q     <= 1'b0;
        end else begin
            sync1_q       <= btn_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            move_dir_q    <= move_dir_d;
            pend_dir_q    <= pend_dir_d;
            pend_vld_q    <= pend_vld_d;
            dir_chg_q     <= dir_chg_d;
        end
    end

    assign move_direction = move_dir_q;
    assign pending_dir    = pend_dir_q;
    assign pending_valid  = pend_vld_q;
    assign dir_changed    = dir_chg_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios then random buttons/ticks, two instances (reversal rejected / allowed).
// Latency: outputs compared every cycle on the falling edge against a behavioural model.
// Backpressure: none; stimulus is free-running.
module tb_snake_dir_ctrl;

    localparam int DC   = 4;
    localparam int RDIR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_n;
    logic       move_tick;

    logic [1:0] move0, pend0, move1, pend1;
    logic       pv0, dc0, pv1, dc1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(DC), .RESET_DIR(2'(RDIR)), .ALLOW_REVERSE(1'b0)) dut_norev (
        .clk(clk), .reset(reset), .btn_n(btn_n), .move_tick(move_tick),
        .move_direction(move0), .pending_dir(pend0), .pending_valid(pv0), .dir_changed(dc0)
    );

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(DC), .RESET_DIR(2'(RDIR)), .ALLOW_REVERSE(1'b1)) dut_rev (
        .clk(clk), .reset(reset), .btn_n(btn_n), .move_tick(move_tick),
        .move_direction(move1), .pending_dir(pend1), .pending_valid(pv1), .dir_changed(dc1)
    );

    // ---------------- behavioural model ----------------
    // Button path: two-sample delay line, then a level is believed once it has
    // disagreed with the believed level for DC samples in a row. A new pressed
    // level becomes a request one cycle later.
    logic [3:0] m_dl[$];
    logic [3:0] m_stab;
    int         m_run[4];
    logic [3:0] m_ev;
    // Per instance: index 0 rejects reversals, index 1 allows them.
    int         m_move[2];
    int         m_pend[2];
    bit         m_pv[2];
    bit         m_dc[2];

    task automatic model_reset();
        m_dl   = '{4'hF, 4'hF};
        m_stab = 4'hF;
        m_ev   = 4'h0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        for (int k = 0; k < 2; k++) begin
            m_move[k] = RDIR;
            m_pend[k] = RDIR;
            m_pv[k]   = 1'b0;
            m_dc[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] b, input bit tick);
        logic [3:0] ev_old;
        logic [3:0] seen;
        int         r;
        int         req;
        bit         acc;
        ev_old = m_ev;
        seen   = m_dl[0];
        m_ev   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] != m_stab[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DC) begin
                    m_stab[i] = seen[i];
                    m_run[i]  = 0;
                    if (seen[i] == 1'b0) m_ev[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        req = -1;
        for (int d = 0; d < 4; d++) if (ev_old[d] && req < 0) req = d;
        for (int k = 0; k < 2; k++) begin
            r   = m_pv[k] ? m_pend[k] : m_move[k];
            acc = (req >= 0) && (req != r) && (k == 1 || req != (r + 2) % 4);
            m_dc[k] = 1'b0;
            if (tick && m_pv[k]) begin
                m_move[k] = m_pend[k];
                m_pv[k]   = 1'b0;
                m_dc[k]   = 1'b1;
            end
            if (acc) begin
                m_pend[k] = req;
                m_pv[k]   = 1'b1;
            end
        end
        m_dl.push_back(b);
        void'(m_dl.pop_front());
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("norev.move_direction", move0, m_move[0]);
        chk("norev.pending_valid",  pv0,   m_pv[0]);
        chk("norev.dir_changed",    dc0,   m_dc[0]);
        if (m_pv[0]) chk("norev.pending_dir", pend0, m_pend[0]);
        chk("rev.move_direction",   move1, m_move[1]);
        chk("rev.pending_valid",    pv1,   m_pv[1]);
        chk("rev.dir_changed",      dc1,   m_dc[1]);
        if (m_pv[1]) chk("rev.pending_dir", pend1, m_pend[1]);
    endtask

    // Drive for one edge, advance the model, compare on the falling edge.
    task automatic do_cycle(input logic [3:0] b, input bit tick);
        btn_n     = b;
        move_tick = tick;
        @(posedge clk);
        if (reset) model_step(b, tick);
        else       model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) do_cycle(b, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        chk("async_rst.move_direction", move0, RDIR);
        chk("async_rst.pending_dir",    pend0, RDIR);
        chk("async_rst.pending_valid",  pv0,   0);
        chk("async_rst.dir_changed",    dc0,   0);
        chk("async_rst.rev_pending_valid", pv1, 0);
        model_reset();
        do_cycle(btn_n, 1'b1);
        reset = 1'b1;
    endtask

    localparam logic [3:0] B_NONE  = 4'b1111;
    localparam logic [3:0] B_LEFT  = 4'b1110;
    localparam logic [3:0] B_UP    = 4'b1101;
    localparam logic [3:0] B_RIGHT = 4'b1011;
    localparam logic [3:0] B_DOWN  = 4'b0111;

    initial begin
        logic [3:0] pat;
        int         len;
        int         sel;
        reset     = 1'b0;
        btn_n     = B_NONE;
        move_tick = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset.move_direction", move0, RDIR);
        chk("reset.pending_valid",  pv0,   0);
        compare_all();
        do_cycle(B_NONE, 1'b1);
        do_cycle(B_NONE, 1'b0);
        reset = 1'b1;

        // Idle after reset
        hold(B_NONE, 4);
        chk("t1.move_direction", move0, 2);
        chk("t1.pending_valid",  pv0,   0);
        chk("t1.dir_changed",    dc0,   0);

        // Left from right: reversal rejected, accepted when allowed
        hold(B_LEFT, 10);
        chk("t3.norev_pending_valid", pv0, 0);
        chk("t3.rev_pending_valid",   pv1, 1);
        chk("t3.rev_pending_dir",     pend1, 0);
        hold(B_NONE, 8);

        // Up held: pending exactly at edge DC+3, then commit on tick
        for (int e = 1; e <= 10; e++) begin
            do_cycle(B_UP, 1'b0);
            if (e == DC + 2) chk("t2.pending_valid_early", pv0, 0);
            if (e == DC + 3) begin
                chk("t2.pending_valid", pv0, 1);
                chk("t2.pending_dir",   pend0, 1);
            end
        end
        do_cycle(B_NONE, 1'b1);
        chk("t2.move_direction", move0, 1);
        chk("t2.dir_changed",    dc0,   1);
        do_cycle(B_NONE, 1'b0);
        chk("t2.dir_changed_pulse", dc0, 0);
        chk("t2.rev_move_direction", move1, 1);
        hold(B_NONE, 8);

        // Turn left so down is legal
        hold(B_LEFT, 8);
        do_cycle(B_NONE, 1'b1);
        chk("t4.move_left", move0, 0);
        hold(B_NONE, 8);

        // Short glitch ignored, long hold accepted
        hold(B_DOWN, 3);
        hold(B_NONE, 8);
        chk("t4.glitch_pending_valid", pv0, 0);
        hold(B_DOWN, 8);
        chk("t4.pending_dir",   pend0, 3);
        chk("t4.pending_valid", pv0,   1);
        do_cycle(B_NONE, 1'b1);
        chk("t4.move_down", move0, 3);
        hold(B_NONE, 8);
        hold(B_RIGHT, 8);
        do_cycle(B_NONE, 1'b1);
        chk("t5.move_right", move0, 2);
        hold(B_NONE, 8);

        // Reversal judged against pending, last accepted wins
        hold(B_UP, 8);
        hold(B_NONE, 8);
        hold(B_DOWN, 8);
        hold(B_NONE, 8);
        chk("t5.down_rejected_dir",   pend0, 1);
        chk("t5.down_rejected_valid", pv0,   1);
        hold(B_LEFT, 8);
        hold(B_NONE, 8);
        chk("t5.left_overwrites", pend0, 0);
        do_cycle(B_NONE, 1'b1);
        chk("t5.commit_left", move0, 0);
        hold(B_NONE, 8);

        // Tick coincides with acceptance of a new press
        hold(B_UP, 8);
        hold(B_NONE, 8);
        for (int e = 1; e <= DC + 3; e++) do_cycle(B_LEFT, e == DC + 3);
        chk("t6.move_direction", move0, 1);
        chk("t6.pending_dir",    pend0, 0);
        chk("t6.pending_valid",  pv0,   1);
        chk("t6.dir_changed",    dc0,   1);
        hold(B_LEFT, 2);
        pulse_reset();
        // Still held after reset: one fresh event; left reverses right
        hold(B_LEFT, 10);
        chk("t6.post_rst_norev_valid", pv0, 0);
        chk("t6.post_rst_rev_dir",     pend1, 0);
        chk("t6.post_rst_rev_valid",   pv1, 1);
        hold(B_NONE, 8);

        // Random stimulus
        for (int seg = 0; seg < 400; seg++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       pat = ~(4'b0001 << sel);
            else if (sel == 4) pat = 4'($urandom_range(0, 15));
            else               pat = B_NONE;
            len = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) do_cycle(pat, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
